lcd_spi_writer: RTL and testbench
=================================

Name: lcd_spi_writer

Overview:
- Physical-layer responder beneath the LCD command/pixel sequencer.
- Accepts one-cycle request pulses on en_i and returns one-cycle done_o pulses.
- en_i[0]/done_o[0]: panel hardware-reset sequence.
- en_i[1]/done_o[1]: one 9-bit word (bit 8 = D/C, bits 7:0 = payload) shifted to the ST7735-class panel over 4-wire SPI, mode 0, MSB first.

Parameters:
- CLK_DIV, 4: clk cycles per SCL half-period; legal range >= 1.
- RST_LOW_CYC, 50_000: cycles lcd_rst_n is held low (1 ms at 50 MHz); legal range >= 1.
- RST_WAIT_CYC, 6_000_000: cycles waited after lcd_rst_n release before done_o[0] (120 ms); legal range >= 1.

Ports:
- clk  in  1  system clock; all outputs registered on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en_i  in  2  request pulses; [0] = panel reset, [1] = write word.
- data_i  in  9  word to write; sampled only in the cycle en_i[1] is accepted.
- done_o  out  2  one-cycle completion pulses matching en_i bits.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- lcd_rst_n  out  1  panel reset, active low.
- lcd_cs_n  out  1  SPI chip select, active low.
- lcd_dc  out  1  data/command select; 1 = data.
- lcd_scl  out  1  SPI clock; idles low.
- lcd_sda  out  1  SPI data.

Behaviour:
- Reset values: done_o=0, busy_o=0, lcd_rst_n=1, lcd_cs_n=1, lcd_dc=1, lcd_scl=0, lcd_sda=0, all counters=0, FSM=IDLE.
- Reset asserted mid-operation: returns to these values asynchronously and no done pulse is issued.
- FSM states: IDLE, RST_LOW, RST_WAIT, SHIFT_LO, SHIFT_HI, FINISH.
- Request acceptance is evaluated only in IDLE. en_i seen in any other state is ignored, neither queued nor acknowledged.
- If en_i = 2'b11 in IDLE, the reset request wins and the write request is dropped.
- Reset sequence, with en_i[0] sampled high at cycle t:
  - t+1: lcd_rst_n=0, state RST_LOW.
  - t+1+RST_LOW_CYC: lcd_rst_n=1, state RST_WAIT.
  - t+1+RST_LOW_CYC+RST_WAIT_CYC: done_o[0]=1 for exactly one cycle, state IDLE.
  - lcd_cs_n, lcd_scl and lcd_sda remain at idle values throughout.
- Write sequence, with en_i[1] sampled high at cycle t and D = CLK_DIV:
  - Cycle t: data_i latched into an internal shift register.
  - t+1: lcd_cs_n=0, lcd_dc=data[8], lcd_sda=data[7], lcd_scl=0.
  - Bit k (k = 0..7, bit sent = data[7-k]):
    - SCL low phase: cycles t+1+2kD .. t+1+2kD+D-1; lcd_sda is updated at the start of this phase.
    - SCL high phase: the next D cycles, with lcd_scl=1.
  - lcd_sda and lcd_dc are stable for the whole high phase; the panel samples on the rising edge.
  - t+1+16D (FINISH): lcd_scl=0, lcd_cs_n=1, done_o[1]=1 for exactly one cycle.
  - t+2+16D: back in IDLE, ready to accept a new request in that cycle.
  - lcd_dc holds its last value after the transfer.
- Total write latency (en_i sample to done pulse) is 1+16*CLK_DIV cycles; 65 cycles for the default.
- lcd_sda after the transfer holds the last bit shifted (data[0]).
- Counter widths: the half-period counter is $clog2(CLK_DIV+1) bits; the reset-delay counter is sized for the larger of RST_LOW_CYC and RST_WAIT_CYC. No wrap is possible within legal parameter values.
- Bit counter: 3 bits; the transfer ends after bit index 7 completes its high phase.
- busy_o is high from t+1 through the done cycle inclusive, and low in IDLE.
- The two done_o bits are never high simultaneously.

Test Plan:
1. Param override CLK_DIV=2, RST_LOW_CYC=10, RST_WAIT_CYC=20; pulse en_i=2'b01 at cycle 0.
   -> lcd_rst_n low for cycles 1..10; done_o=2'b01 only at cycle 31; cs_n stays 1.
2. CLK_DIV=2; en_i=2'b10 with data_i=9'h02A at cycle 0.
   -> cs_n low during cycles 1..32; lcd_dc=0; 8 rising SCL edges (cycles 3,7,...,31) sample bits 0,0,1,0,1,0,1,0; done_o=2'b10 at cycle 33; cs_n=1 at 33.
3. Write 9'h1F8, then re-pulse en_i[1] with 9'h100 the cycle after done.
   -> second transfer accepted; lcd_dc=1 for both; sampled bytes F8 then 00; two done_o[1] pulses 34 cycles apart.
4. en_i=2'b11 in IDLE.
   -> only the reset sequence runs; exactly one done_o[0] pulse; no done_o[1]; cs_n never low.
5. During a write, pulse en_i[1] at cycle 10 with a different data_i and toggle data_i continuously.
   -> transmitted byte equals the value latched at cycle 0; only one done pulse.
6. Assert rst at cycle 12 of a write (CLK_DIV=2) for 3 cycles.
   -> outputs return immediately to reset values (cs_n=1, scl=0, rst_n=1); no done pulse; a new write after release completes normally.

Source files
------------

// File: rtl/lcd_spi_writer.sv
// SPI/reset physical layer for an ST7735-class panel: runs the panel hardware-reset
// timing or shifts one 9-bit D/C+payload word out in SPI mode 0, MSB first.
module lcd_spi_writer #(
    parameter int CLK_DIV      = 4,
    parameter int RST_LOW_CYC  = 50_000,
    parameter int RST_WAIT_CYC = 6_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] en_i,
    input  logic [8:0] data_i,
    output logic [1:0] done_o,
    output logic       busy_o,
    output logic       lcd_rst_n,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic       lcd_scl,
    output logic       lcd_sda
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int RMAX   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int RCNT_W = $clog2(RMAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [RCNT_W-1:0] RLOW_LAST = RCNT_W'(RST_LOW_CYC - 1);
    localparam logic [RCNT_W-1:0] RWAI_LAST = RCNT_W'(RST_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, RST_LOW, RST_WAIT, SHIFT_LO, SHIFT_HI, FINISH
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DIV_W-1:0]    r_div;
    logic [RCNT_W-1:0]   r_rcnt;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;

    logic                w_div_end;
    logic                w_rlow_end;
    logic                w_rwait_end;
    logic                w_accept_wr;
    logic                w_next_bit;
    logic [1:0]          w_done_nxt;
    logic                w_busy_nxt;
    logic                w_rst_n_nxt;
    logic                w_cs_n_nxt;
    logic                w_scl_nxt;
    logic                w_dc_nxt;
    logic                w_sda_nxt;

    assign w_div_end   = (r_div == DIV_LAST);
    assign w_rlow_end  = (r_rcnt == RLOW_LAST);
    assign w_rwait_end = (r_rcnt == RWAI_LAST);
    assign w_accept_wr = (r_state == IDLE) && (w_next == SHIFT_LO);
    assign w_next_bit  = (r_state == SHIFT_HI) && (w_next == SHIFT_LO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Requests are only looked at in IDLE; the reset request has priority.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (en_i[0])      w_next = RST_LOW;
                else if (en_i[1]) w_next = SHIFT_LO;
            end
            RST_LOW:  if (w_rlow_end)  w_next = RST_WAIT;
            RST_WAIT: if (w_rwait_end) w_next = IDLE;
            SHIFT_LO: if (w_div_end)   w_next = SHIFT_HI;
            SHIFT_HI: if (w_div_end)   w_next = (r_bit == 3'd7) ? FINISH : SHIFT_LO;
            FINISH:   w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Next values of the registered pins, derived from the upcoming state.
    always_comb begin
        w_done_nxt    = 2'b00;
        w_done_nxt[0] = (r_state == RST_WAIT) && w_rwait_end;
        w_done_nxt[1] = (w_next == FINISH);
        w_busy_nxt    = (w_next != IDLE) || (|w_done_nxt);
        w_rst_n_nxt   = (w_next != RST_LOW);
        w_cs_n_nxt    = !((w_next == SHIFT_LO) || (w_next == SHIFT_HI));
        w_scl_nxt     = (w_next == SHIFT_HI);
        w_dc_nxt      = lcd_dc;
        w_sda_nxt     = lcd_sda;
        if (w_accept_wr) begin
            w_dc_nxt  = data_i[8];
            w_sda_nxt = data_i[7];
        end else if (w_next_bit) begin
            w_sda_nxt = r_shift[6];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_o    <= 2'b00;
            busy_o    <= 1'b0;
            lcd_rst_n <= 1'b1;
            lcd_cs_n  <= 1'b1;
            lcd_dc    <= 1'b1;
            lcd_scl   <= 1'b0;
            lcd_sda   <= 1'b0;
            r_div     <= '0;
            r_rcnt    <= '0;
            r_bit     <= '0;
        end else begin
            done_o    <= w_done_nxt;
            busy_o    <= w_busy_nxt;
            lcd_rst_n <= w_rst_n_nxt;
            lcd_cs_n  <= w_cs_n_nxt;
            lcd_dc    <= w_dc_nxt;
            lcd_scl   <= w_scl_nxt;
            lcd_sda   <= w_sda_nxt;

            if (((r_state == SHIFT_LO) || (r_state == SHIFT_HI)) && !w_div_end)
                r_div <= r_div + 1'b1;
            else
                r_div <= '0;

            if (((r_state == RST_LOW) && !w_rlow_end) ||
                ((r_state == RST_WAIT) && !w_rwait_end))
                r_rcnt <= r_rcnt + 1'b1;
            else
                r_rcnt <= '0;

            if (w_accept_wr)     r_bit <= '0;
            else if (w_next_bit) r_bit <= r_bit + 1'b1;
        end
    end

    // Payload shift register; its contents only matter while a transfer runs.
    always_ff @(posedge clk) begin
        if (w_accept_wr)     r_shift <= data_i[7:0];
        else if (w_next_bit) r_shift <= {r_shift[6:0], 1'b0};
    end

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Directed bench for lcd_spi_writer with CLK_DIV=2, RST_LOW_CYC=10, RST_WAIT_CYC=20.
module tb_lcd_spi_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] en_i = 2'b00;
    logic [8:0] data_i = 9'h000;
    logic [1:0] done_o;
    logic       busy_o, lcd_rst_n, lcd_cs_n, lcd_dc, lcd_scl, lcd_sda;

    int total = 0;
    int bad   = 0;

    // monitor state (written only by the monitor process)
    int       gcyc = 0;
    logic     prev_scl = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    logic     mon_dc = 1'b0;
    int       n_bits = 0, n_done0 = 0, n_done1 = 0, n_cs_low = 0, n_both = 0;

    lcd_spi_writer #(.CLK_DIV(2), .RST_LOW_CYC(10), .RST_WAIT_CYC(20)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .data_i(data_i), .done_o(done_o),
        .busy_o(busy_o), .lcd_rst_n(lcd_rst_n), .lcd_cs_n(lcd_cs_n), .lcd_dc(lcd_dc),
        .lcd_scl(lcd_scl), .lcd_sda(lcd_sda)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        gcyc = gcyc + 1;
        if (lcd_scl && !prev_scl) begin
            mon_byte = {mon_byte[6:0], lcd_sda};
            mon_dc   = lcd_dc;
            n_bits   = n_bits + 1;
        end
        prev_scl = lcd_scl;
        if (done_o[0]) n_done0 = n_done0 + 1;
        if (done_o[1]) n_done1 = n_done1 + 1;
        if (!lcd_cs_n) n_cs_low = n_cs_low + 1;
        if (&done_o)   n_both = n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, gcyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [1:0] en, input logic [8:0] d, output int t0);
        en_i   = en;
        data_i = d;
        t0     = gcyc;
        tick();
        en_i   = 2'b00;
    endtask

    task automatic wait_done1(input int limit, output int when);
        int n;
        n = 0;
        while (!done_o[1] && n < limit) begin
            tick();
            n++;
        end
        when = gcyc;
        check("done1_timeout", {31'd0, done_o[1]}, 32'd1);
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, "_cs_n"},  {31'd0, lcd_cs_n},  32'd1);
        check({tag, "_scl"},   {31'd0, lcd_scl},   32'd0);
        check({tag, "_rst_n"}, {31'd0, lcd_rst_n}, 32'd1);
        check({tag, "_busy"},  {31'd0, busy_o},    32'd0);
        check({tag, "_done"},  {30'd0, done_o},    32'd0);
    endtask

    initial begin
        int t0, rel, b0, d0, d1, cs0, c1, c2, k;
        logic [8:0] d;
        logic [1:0] exp_done;

        repeat (3) @(posedge clk);
        #2;
        check_idle_pins("reset");
        check("reset_dc",  {31'd0, lcd_dc},  32'd1);
        check("reset_sda", {31'd0, lcd_sda}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: panel reset sequence
        cs0 = n_cs_low; d0 = n_done0;
        pulse(2'b01, 9'h000, t0);
        for (int i = 1; i <= 35; i++) begin
            rel = gcyc - t0;
            exp_done = (rel == 31) ? 2'b01 : 2'b00;
            check("t1_rst_n", {31'd0, lcd_rst_n}, (rel >= 1 && rel <= 10) ? 32'd0 : 32'd1);
            check("t1_done",  {30'd0, done_o}, {30'd0, exp_done});
            check("t1_busy",  {31'd0, busy_o}, (rel <= 31) ? 32'd1 : 32'd0);
            tick();
        end
        check("t1_cs_low", n_cs_low - cs0, 0);
        check("t1_n_done0", n_done0 - d0, 1);

        // 2: single write of 0x02A, every pin checked per cycle
        d = 9'h02A;
        d1 = n_done1;
        pulse(2'b10, d, t0);
        for (int i = 1; i <= 35; i++) begin
            rel = gcyc - t0;
            exp_done = (rel == 33) ? 2'b10 : 2'b00;
            k = (rel <= 32) ? (rel - 1) / 4 : 7;
            check("t2_cs_n", {31'd0, lcd_cs_n}, (rel <= 32) ? 32'd0 : 32'd1);
            check("t2_scl",  {31'd0, lcd_scl},
                  (rel <= 32 && ((rel - 1) / 2) % 2 == 1) ? 32'd1 : 32'd0);
            check("t2_sda",  {31'd0, lcd_sda}, {31'd0, d[7-k]});
            check("t2_dc",   {31'd0, lcd_dc}, 32'd0);
            check("t2_done", {30'd0, done_o}, {30'd0, exp_done});
            tick();
        end
        check("t2_byte", {24'd0, mon_byte}, 32'h2A);
        check("t2_n_done1", n_done1 - d1, 1);

        // 3: back-to-back writes, second issued the cycle after done
        b0 = n_bits;
        pulse(2'b10, 9'h1F8, t0);
        wait_done1(40, c1);
        check("t3_lat1", c1 - t0, 33);
        check("t3_byte1", {24'd0, mon_byte}, 32'hF8);
        check("t3_dc1", {31'd0, mon_dc}, 32'd1);
        tick();
        pulse(2'b10, 9'h100, t0);
        wait_done1(40, c2);
        check("t3_gap", c2 - c1, 34);
        check("t3_byte2", {24'd0, mon_byte}, 32'h00);
        check("t3_dc2", {31'd0, mon_dc}, 32'd1);
        check("t3_bits", n_bits - b0, 16);
        repeat (3) tick();

        // 4: simultaneous requests: reset wins
        cs0 = n_cs_low; d0 = n_done0; d1 = n_done1;
        pulse(2'b11, 9'h0FF, t0);
        repeat (40) tick();
        check("t4_n_done0", n_done0 - d0, 1);
        check("t4_n_done1", n_done1 - d1, 0);
        check("t4_cs_low", n_cs_low - cs0, 0);

        // 5: requests and data changes during a transfer are ignored
        d1 = n_done1;
        pulse(2'b10, 9'h0C3, t0);
        for (int i = 1; i <= 44; i++) begin
            rel = gcyc - t0;
            data_i = ~data_i;
            en_i = (rel == 10) ? 2'b10 : 2'b00;
            if (rel == 10) data_i = 9'h1FF;
            tick();
        end
        en_i = 2'b00;
        check("t5_byte", {24'd0, mon_byte}, 32'hC3);
        check("t5_dc", {31'd0, mon_dc}, 32'd0);
        check("t5_n_done1", n_done1 - d1, 1);

        // 6: asynchronous reset in the middle of a write
        d1 = n_done1;
        pulse(2'b10, 9'h0AA, t0);
        while (gcyc - t0 < 12) tick();
        check("t6_cs_active", {31'd0, lcd_cs_n}, 32'd0);
        rst = 1'b1;
        #1;
        check_idle_pins("t6_async");
        check("t6_dc", {31'd0, lcd_dc}, 32'd1);
        check("t6_sda", {31'd0, lcd_sda}, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (40) tick();
        check("t6_no_done", n_done1 - d1, 0);
        pulse(2'b10, 9'h155, t0);
        wait_done1(40, c1);
        check("t6_lat", c1 - t0, 33);
        check("t6_byte", {24'd0, mon_byte}, 32'h55);
        check("t6_dc_after", {31'd0, mon_dc}, 32'd1);
        tick();
        check("t6_sda_hold", {31'd0, lcd_sda}, 32'd1);
        check_idle_pins("t6_end");

        check("both_done_never", n_both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
